spi_adc_frame_rx: RTL and testbench

- Parametrised SPI master for serial multi-channel ADCs of the LTC1407 class; successor to the fixed 2×14-bit dual-channel reader.
- Generates the conversion strobe and a divided SCK from the system clock.
- Deserialises NCH channels of DW bits each, with configurable dead bits, and presents them as one packed word with a valid pulse.
- Supports single-shot and continuous modes, and can discard the first frame after reset because that frame holds stale pipeline data.

---
 rtl/spi_adc_frame_rx.sv | 164 ++++++++++++++++
 tb/tb_spi_adc_frame_rx.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_adc_frame_rx.sv
// SPI master / deserialiser for LTC1407-class multi-channel ADCs: conversion strobe, divided SCK, packed frame out.
// Optional overrun reporting is compiled in with `define SPI_ADC_OVERRUN_EN.
module spi_adc_frame_rx #(
  parameter int NCH        = 2,
  parameter int DW         = 14,
  parameter int LEAD       = 2,
  parameter int TAIL       = 2,
  parameter int CLK_DIV    = 1,
  parameter int SKIP_FIRST = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              cont,
  output logic              busy,
  output logic              valid,
  output logic [NCH*DW-1:0] data,
  input  logic              adc_miso,
  output logic              adc_conv,
  output logic              spi_sck
`ifdef SPI_ADC_OVERRUN_EN
  ,
  output logic              overrun,
  output logic [7:0]        overrun_cnt
`endif
);

  localparam int SLOT_W     = LEAD + DW;
  localparam int FRAME_BITS = NCH * SLOT_W + TAIL;
  localparam int BW         = $clog2(FRAME_BITS + 1);
  localparam int OW         = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
  localparam int SW         = $clog2(NCH + 1);
  localparam int DVW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [BW-1:0]  BIT_LAST  = BW'(FRAME_BITS - 1);
  localparam logic [OW-1:0]  OFF_LAST  = OW'(SLOT_W - 1);
  localparam logic [OW-1:0]  OFF_DATA  = OW'(LEAD);
  localparam logic [SW-1:0]  SLOT_TAIL = SW'(NCH);
  localparam logic [DVW-1:0] DIV_LAST  = DVW'(CLK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_SHIFT, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [DVW-1:0]    r_div;
  logic              r_sck;
  logic [BW-1:0]     r_bit;
  logic [SW-1:0]     r_slot;
  logic [OW-1:0]     r_off;
  logic [NCH*DW-1:0] r_shift;
  logic [NCH*DW-1:0] r_data;
  logic              r_valid;
  logic              r_skip;
  logic              w_run, w_wrap, w_rise, w_fall;

  assign w_run  = (r_state == S_CONV) || (r_state == S_SHIFT);
  assign w_wrap = w_run && (r_div == DIV_LAST);
  assign w_rise = (r_state == S_SHIFT) && w_wrap && !r_sck;
  assign w_fall = (r_state == S_SHIFT) && w_wrap && r_sck;

  // NOTE: next state gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_CONV;
      S_CONV:  if (w_wrap && r_sck) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_fall && (r_bit == BIT_LAST)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = cont ? S_CONV : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: all state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // SCK divider plus bit/slot/offset counters; each SCK period begins low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div  <= '0;
      r_sck  <= 1'b0;
      r_bit  <= '0;
      r_slot <= '0;
      r_off  <= '0;
    end else begin
      if (w_run) begin
        if (w_wrap) begin
          r_div <= '0;
          r_sck <= ~r_sck;
        end else begin
          r_div <= r_div + 1'b1;
        end
      end else begin
        r_div <= '0;
        r_sck <= 1'b0;
      end

      if (r_state != S_SHIFT) begin
        r_bit  <= '0;
        r_slot <= '0;
        r_off  <= '0;
      end else if (w_fall) begin
        r_bit <= r_bit + 1'b1;
        if (r_off == OFF_LAST) begin
          r_off <= '0;
          if (r_slot != SLOT_TAIL) r_slot <= r_slot + 1'b1;
        end else begin
          r_off <= r_off + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_skip  <= (SKIP_FIRST != 0);
    end else begin
      r_valid <= 1'b0;
      // Lead bits and tail slot (r_slot == NCH) never match a channel, so they fall away here.
      if (w_rise && (r_off >= OFF_DATA)) begin
        for (int k = 0; k < NCH; k++) begin
          if (r_slot == SW'(k)) r_shift[k*DW +: DW] <= {r_shift[k*DW +: DW-1], adc_miso};
        end
      end
      if ((r_state == S_SHIFT) && (w_state_nxt == S_DONE)) begin
        if (r_skip) begin
          r_skip <= 1'b0;
        end else begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end
      end
    end
  end

`ifdef SPI_ADC_OVERRUN_EN
  logic       r_ovr;
  logic [7:0] r_ovr_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovr     <= 1'b0;
      r_ovr_cnt <= '0;
    end else begin
      r_ovr <= start && busy;
      if (start && busy && (r_ovr_cnt != 8'hFF)) r_ovr_cnt <= r_ovr_cnt + 1'b1;
    end
  end

  assign overrun     = r_ovr;
  assign overrun_cnt = r_ovr_cnt;
`endif

  assign busy     = (r_state != S_IDLE);
  assign adc_conv = (r_state == S_CONV);
  assign spi_sck  = r_sck;
  assign valid    = r_valid;
  assign data     = r_data;

endmodule

// File: tb/tb_spi_adc_frame_rx.sv
// Bench for spi_adc_frame_rx: default instance (A) and CLK_DIV=3 / SKIP_FIRST=0 instance (B), each with an ADC model.
// Expected frames go into per-instance queues when a start is driven and are compared when valid pulses.
module tb_spi_adc_frame_rx;

  localparam int FB = 34;

  typedef struct {
    logic [27:0] data;
    int          due;
  } exp_t;

  typedef struct {
    logic [13:0] ch0;
    logic [13:0] ch1;
    logic [27:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_a = 1'b0, cont_a = 1'b0, start_b = 1'b0, cont_b = 1'b0;
  logic        busy_a, valid_a, conv_a, sck_a;
  logic        busy_b, valid_b, conv_b, sck_b;
  logic [27:0] data_a, data_b;
  logic        miso_a, miso_b;
  logic [33:0] stream_a = '0, stream_b = '0;
  logic        dead_a = 1'b0, dead_b = 1'b0;
  int          idx_a = -1, idx_b = -1;
  int          cyc = 0;
  int          n_checks = 0, n_errors = 0;
  exp_t        q_a[$], q_b[$];
  exp_t        e_a, e_b;
`ifdef SPI_ADC_OVERRUN_EN
  logic        ovr_a, ovr_b;
  logic [7:0]  ovr_cnt_a, ovr_cnt_b;
  int          n_ovr = 0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_adc_frame_rx u_dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .cont(cont_a),
    .busy(busy_a), .valid(valid_a), .data(data_a),
    .adc_miso(miso_a), .adc_conv(conv_a), .spi_sck(sck_a)
`ifdef SPI_ADC_OVERRUN_EN
    , .overrun(ovr_a), .overrun_cnt(ovr_cnt_a)
`endif
  );

  spi_adc_frame_rx #(.CLK_DIV(3), .SKIP_FIRST(0)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .cont(cont_b),
    .busy(busy_b), .valid(valid_b), .data(data_b),
    .adc_miso(miso_b), .adc_conv(conv_b), .spi_sck(sck_b)
`ifdef SPI_ADC_OVERRUN_EN
    , .overrun(ovr_b), .overrun_cnt(ovr_cnt_b)
`endif
  );

  // ADC models: bit 0 appears when CONV ends, each following SCK fall presents the next bit.
  always @(posedge conv_a) idx_a = -1;
  always @(negedge sck_a)  idx_a = idx_a + 1;
  always @(posedge conv_b) idx_b = -1;
  always @(negedge sck_b)  idx_b = idx_b + 1;
  assign miso_a = (idx_a >= 0 && idx_a < FB) ? stream_a[idx_a] : dead_a;
  assign miso_b = (idx_b >= 0 && idx_b < FB) ? stream_b[idx_b] : dead_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Serial image of one frame: LEAD dead bits then 14 data bits MSB-first per channel, then TAIL dead bits.
  function automatic logic [33:0] mk_stream(input logic [13:0] c0, input logic [13:0] c1, input logic dead);
    logic [33:0] s;
    logic [13:0] ch;
    for (int b = 0; b < FB; b++) begin
      int slot, off;
      slot = b / 16;
      off  = b % 16;
      ch   = (slot == 0) ? c0 : c1;
      if (slot < 2 && off >= 2) s[b] = ch[15-off];
      else                      s[b] = dead;
    end
    return s;
  endfunction

  always @(negedge clk) begin
    if (valid_a) begin
      if (q_a.size() == 0) check("A valid without pending frame", valid_a, 1'b0);
      else begin
        e_a = q_a.pop_front();
        check("A frame data", data_a, e_a.data);
        check("A valid cycle", cyc, e_a.due);
      end
    end
    if (valid_b) begin
      if (q_b.size() == 0) check("B valid without pending frame", valid_b, 1'b0);
      else begin
        e_b = q_b.pop_front();
        check("B frame data", data_b, e_b.data);
        check("B valid cycle", cyc, e_b.due);
      end
    end
  end

`ifdef SPI_ADC_OVERRUN_EN
  always @(negedge clk) if (ovr_a === 1'b1) n_ovr++;
`endif

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic pulse_a(output int acc);
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1 acc = cyc;
    @(negedge clk); start_a = 1'b0;
  endtask

  task automatic pulse_b(output int acc);
    @(negedge clk); start_b = 1'b1;
    @(posedge clk); #1 acc = cyc;
    @(negedge clk); start_b = 1'b0;
  endtask

  task automatic poke_a();
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not reach its summary, errors so far %0d", n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[4];
    int   acc, rises, conv_hi, first_rise, second_rise;
    logic prev;
`ifdef SPI_ADC_OVERRUN_EN
    int         base_ovr;
    logic [7:0] base_cnt;
`endif
    vecs[0] = '{14'h3FFF, 14'h0000, 28'h0003FFF};
    vecs[1] = '{14'h0000, 14'h3FFF, 28'hFFFC000};
    vecs[2] = '{14'h2AAA, 14'h1555, 28'h5556AAA};
    vecs[3] = '{14'h0001, 14'h2000, 28'h8000001};

    repeat (3) @(negedge clk);
    check("reset busy A", busy_a, 1'b0);
    check("reset valid A", valid_a, 1'b0);
    check("reset conv A", conv_a, 1'b0);
    check("reset sck A", sck_a, 1'b0);
    check("reset data A", data_a, 28'h0);
    check("reset busy B", busy_b, 1'b0);
    check("reset data B", data_b, 28'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // First frame after reset is discarded on A.
    stream_a = mk_stream(14'h1ABC, 14'h2345, 1'b0);
    pulse_a(acc);
    check("A conv on accept", conv_a, 1'b1);
    check("A busy on accept", busy_a, 1'b1);
    wait_cyc(acc + 70);
    check("A busy in skipped DONE", busy_a, 1'b1);
    check("A skipped frame valid", valid_a, 1'b0);
    wait_cyc(acc + 71);
    check("A busy after skipped frame", busy_a, 1'b0);
    check("A data after skipped frame", data_a, 28'h0);
    pulse_a(acc);
    q_a.push_back(exp_t'{{14'h2345, 14'h1ABC}, acc + 70});
    wait_cyc(acc + 71);
    check("A busy after frame 2", busy_a, 1'b0);
    check("A data after frame 2", data_a, {14'h2345, 14'h1ABC});

    // Table of patterns; a stray start mid-frame must be ignored.
    for (int i = 0; i < 4; i++) begin
      stream_a = mk_stream(vecs[i].ch0, vecs[i].ch1, (i % 2) == 1);
      dead_a   = ((i % 2) == 1);
      pulse_a(acc);
      q_a.push_back(exp_t'{vecs[i].exp, acc + 70});
      wait_cyc(acc + 30);
      poke_a();
      wait_cyc(acc + 71);
      check("table busy dropped", busy_a, 1'b0);
      wait_cyc(acc + 80);
      check("table data held", data_a, vecs[i].exp);
    end
    dead_a = 1'b0;

    // B: CLK_DIV=3 timing, first frame is delivered.
    stream_b = mk_stream(14'h0F0F, 14'h3210, 1'b0);
    pulse_b(acc);
    q_b.push_back(exp_t'{{14'h3210, 14'h0F0F}, acc + 210});
    rises = 0; conv_hi = 0; prev = 1'b0; first_rise = 0; second_rise = 0;
    while (cyc < acc + 215) begin
      if (conv_b) conv_hi++;
      if (sck_b && !prev && !conv_b) begin
        rises++;
        if (rises == 1) first_rise = cyc;
        if (rises == 2) second_rise = cyc;
      end
      prev = sck_b;
      @(negedge clk);
    end
    check("B conv high clk", conv_hi, 6);
    check("B SCK rises in SHIFT", rises, 34);
    check("B SCK period", second_rise - first_rise, 6);
    check("B busy after frame", busy_b, 1'b0);

    // B: ones on every dead bit, zeros on data bits.
    stream_b = mk_stream(14'h0000, 14'h0000, 1'b1);
    dead_b   = 1'b1;
    pulse_b(acc);
    q_b.push_back(exp_t'{28'h0, acc + 210});
    wait_cyc(acc + 211);
    check("B lead/tail discarded", data_b, 28'h0);

    // Continuous mode on A.
    stream_a = mk_stream(14'h0123, 14'h3ED0, 1'b0);
    cont_a = 1'b1;
    repeat (10) @(negedge clk);
    check("A cont without start stays idle", busy_a, 1'b0);
    pulse_a(acc);
    q_a.push_back(exp_t'{{14'h3ED0, 14'h0123}, acc + 70});
    q_a.push_back(exp_t'{{14'h3ED0, 14'h0123}, acc + 141});
    q_a.push_back(exp_t'{{14'h3ED0, 14'h0123}, acc + 212});
    wait_cyc(acc + 70);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("A start+cont in DONE continues", conv_a, 1'b1);
    wait_cyc(acc + 172);
    cont_a = 1'b0;
    wait_cyc(acc + 212);
    check("A busy in last DONE", busy_a, 1'b1);
    wait_cyc(acc + 213);
    check("A busy after cont drop", busy_a, 1'b0);
    wait_cyc(acc + 300);
    check("A stays idle", busy_a, 1'b0);

    // Asynchronous reset at bit 10.
    stream_a = mk_stream(14'h1111, 14'h2222, 1'b0);
    pulse_a(acc);
    wait_cyc(acc + 23);
    check("A sck high at bit 10", sck_a, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("mid reset sck", sck_a, 1'b0);
    check("mid reset conv", conv_a, 1'b0);
    check("mid reset busy", busy_a, 1'b0);
    check("mid reset data", data_a, 28'h0);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    pulse_a(acc);
    wait_cyc(acc + 71);
    check("re-skip data", data_a, 28'h0);
    check("re-skip busy", busy_a, 1'b0);
    pulse_a(acc);
    q_a.push_back(exp_t'{{14'h2222, 14'h1111}, acc + 70});
    wait_cyc(acc + 71);
    check("post-reset frame data", data_a, {14'h2222, 14'h1111});

`ifdef SPI_ADC_OVERRUN_EN
    base_ovr = n_ovr;
    base_cnt = ovr_cnt_a;
    stream_a = mk_stream(14'h0ACE, 14'h3BDF, 1'b0);
    pulse_a(acc);
    q_a.push_back(exp_t'{{14'h3BDF, 14'h0ACE}, acc + 70});
    for (int k = 0; k < 3; k++) begin
      wait_cyc(acc + 10 + 10 * k);
      poke_a();
    end
    wait_cyc(acc + 71);
    check("overrun pulses", n_ovr - base_ovr, 3);
    check("overrun count", ovr_cnt_a, base_cnt + 8'd3);
    check("overrun frame data", data_a, {14'h3BDF, 14'h0ACE});
`endif

    repeat (5) @(negedge clk);
    check("A frames all delivered", q_a.size(), 0);
    check("B frames all delivered", q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
